// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the MIPS execute stage. It shares the
// ALU's A/B operands and owns the HI/LO pair read by mfhi/mflo. It serves
// MULTU, DIVU, MULT, DIV and MTHI/MTLO. One product or quotient bit is
// produced per cycle. The unit takes 33 cycles from an accepted start to done:
// 32 iteration cycles and one sign-fix/write-back cycle.
//
// Optional feature macro: MDU_SIGNED_EN
//   defined   : op[1] = 1 selects two's-complement MULT/DIV.
//   undefined : op[1] is ignored and no magnitude or sign-fix logic is built.
//               The write-back cycle is kept, so latency does not change.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low; clears all state
//   start        in   operation request, sampled only while idle
//   op[1:0]      in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   A[W-1:0]     in   multiplicand / dividend (rs)
//   B[W-1:0]     in   multiplier / divisor (rt)
//   hi_we        in   MTHI write enable (honoured only while idle)
//   lo_we        in   MTLO write enable (honoured only while idle)
//   wdata[W-1:0] in   MTHI/MTLO data
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse; HI/LO are valid with it
//   div_by_zero  out  divide-by-zero flag, valid with done and held until the
//                     next accepted start
//   HI[W-1:0]    out  HI result register
//   LO[W-1:0]    out  LO result register
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             dz_pend;     // divisor was zero at start
  logic [WIDTH-1:0] opd;         // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;      // upper product half / partial remainder
  logic [WIDTH-1:0] acc_lo;      // multiplier bits / dividend bits -> quotient

  // ---------------------------------------------------------------------------
  // Operand conditioning: signed operations iterate on magnitudes. The
  // required sign of each result is recorded at start.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;

`ifdef MDU_SIGNED_EN
  logic neg_q;                   // negate product / quotient
  logic neg_r;                   // negate remainder (dividend was negative)
  logic sgn_q_in;
  logic sgn_r_in;

  always_comb begin
    a_in     = A;
    b_in     = B;
    sgn_q_in = 1'b0;
    sgn_r_in = 1'b0;
    if (op[1]) begin
      // The magnitude of 0x80000000 is 0x80000000 read as unsigned. That is
      // the value the unsigned core needs.
      if (A[WIDTH-1]) a_in = -A;
      if (B[WIDTH-1]) b_in = -B;
      sgn_q_in = A[WIDTH-1] ^ B[WIDTH-1];
      sgn_r_in = A[WIDTH-1];
    end
  end
`else
  logic unused_op_msb;
  assign a_in          = A;
  assign b_in          = B;
  assign unused_op_msb = op[1];
`endif

  // ---------------------------------------------------------------------------
  // One iteration step.
  // Multiply: shift-add with the multiplier in acc_lo. The 33-bit sum keeps
  //   the carry, which shifts into acc_hi's MSB.
  // Divide: restoring. The trial remainder is 33 bits wide. When the trial
  //   value is at least the divisor, the difference is below 2^32, so a
  //   32-bit subtract is exact.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opd});
    if (is_div) begin
      step_hi = div_ge ? (div_trial[WIDTH-1:0] - opd) : div_trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back values for the FIX cycle.
  // Divide by zero: the quotient is forced to all ones. The remainder path
  // already holds |A|, and the remainder sign fix restores it to A, so HI
  // ends up as the original dividend without a separate copy.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
`ifdef MDU_SIGNED_EN
    if (is_div) begin
      if (neg_q) res_lo = -acc_lo;
      if (neg_r) res_hi = -acc_hi;
    end else if (neg_q) begin
      {res_hi, res_lo} = -{acc_hi, acc_lo};
    end
`endif
    if (dz_pend) res_lo = '1;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all state registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      dz_pend     <= 1'b0;
      opd         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
`ifdef MDU_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO may land in the same cycle as a start. The result
          // overwrites them when the operation completes.
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            count       <= '0;
            is_div      <= op[0];
            dz_pend     <= op[0] && (B == '0);
            div_by_zero <= 1'b0;
            opd         <= b_in;
            acc_hi      <= '0;
            acc_lo      <= a_in;
`ifdef MDU_SIGNED_EN
            neg_q       <= sgn_q_in;
            neg_r       <= sgn_r_in;
`endif
          end
        end

        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end

        FIX: begin
          HI          <= res_hi;
          LO          <= res_lo;
          div_by_zero <= dz_pend;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Scoreboard bench for mult_div_unit. Each issued operation pushes its
// hand-computed HI/LO/div_by_zero into a queue. A monitor pops and compares
// on every done pulse. The issuing task also checks latency, busy width and
// that HI/LO hold during the operation. Signed expectations follow
// MDU_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   pushed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 HI=%h LO=%h expected no pending op", HI, LO);
      end else begin
        mon_e = exp_q.pop_front();
        $display("done %s: HI=%h LO=%h dz=%b", mon_e.name, HI, LO, div_by_zero);
        check({mon_e.name, "_hi"}, 64'(HI), 64'(mon_e.hi));
        check({mon_e.name, "_lo"}, 64'(LO), 64'(mon_e.lo));
        check({mon_e.name, "_dz"}, 64'(div_by_zero), 64'(mon_e.dz));
      end
    end
  end

  // Issue one operation and follow it to completion.
  // inject: at cycle 5 of the operation, pulse start and hi_we. Both must be
  //         ignored because the unit is busy.
  // mt_same: assert hi_we in the same cycle as start. The write lands at once.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input bit inject, input bit mt_same);
    exp_t        e;
    int          lat;
    int          bcnt;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    bit          hold_bad;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    if (mt_same) begin
      hi_we = 1'b1;
      wdata = 32'hA5A5_0001;
    end
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.dz   = edz;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    check({name, "_busy_e0"}, 64'(busy), 64'd1);
    check({name, "_dz_clr"}, 64'(div_by_zero), 64'd0);
    if (mt_same) check({name, "_mt_same"}, 64'(HI), 64'h0000_0000_A5A5_0001);
    hold_hi  = HI;
    hold_lo  = LO;
    hold_bad = 1'b0;
    lat      = 0;
    bcnt     = 0;
    while (busy === 1'b1 && lat < 100) begin
      bcnt++;
      if (HI !== hold_hi || LO !== hold_lo) hold_bad = 1'b1;
      if (inject && lat == 5) begin
        start = 1'b1;
        op    = 2'b01;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_cycles"}, 64'(bcnt), 64'd33);
    check({name, "_done_at_e33"}, 64'(done), 64'd1);
    check({name, "_hilo_hold"}, 64'(hold_bad), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    A     = '0;
    B     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI, then MULTU 2x3 with an ignored start/MTHI in the middle
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi", 64'(HI), 64'h1234);
    run_op("multu_2x3", 2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b1, 1'b0);

    // Directed vectors. Consecutive calls are back-to-back: each start is
    // driven in the cycle where done is high.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("multu_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0, 1'b0);
    run_op("divu_100_0", 2'b01, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h2, 32'd14, 1'b0, 1'b0, 1'b0);
`ifdef MDU_SIGNED_EN
    run_op("mult_m3x7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op("mult_m3xm5", 2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'hF, 1'b0, 1'b0, 1'b0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
`else
    run_op("mult_m3x7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op("mult_m3xm5", 2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF8, 32'hF, 1'b0, 1'b0, 1'b0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
`endif
    // A signed divide by zero returns the original dividend in HI, so the
    // expectation is the same in both builds.
    run_op("div_m100_0", 2'b11, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("multu_mt_same", 2'b00, 32'd5, 32'd5, 32'h0, 32'd25, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a DIVU: clears at once, and no done follows.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(HI), 64'd0);
    check("midrst_lo", 64'(LO), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_op("after_reset", 2'b01, 32'd100, 32'd7, 32'h2, 32'd14, 1'b0, 1'b0, 1'b0);

    repeat (40) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(dones), 64'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
